spi_master_gen: RTL and testbench

- Parametrised successor to the fixed-rate DivMMC SPI engine: byte-wide SPI master with programmable SCK divider and selectable clock polarity.
- Drives NUM_CS chip-select lines, and exposes busy/done handshakes so CPU-port glue (DivMMC, ZXMMC and similar) can stall or poll.
- Sits between the CPU I/O decode and the SD/MMC SPI pins, all in the clk_sys domain.

---
 rtl/spi_master_gen.sv | 171 +++++++++++++++++
 tb/tb_spi_master_gen.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_gen.sv
// spi_master_gen: byte-wide SPI master (mode 0 / mode 2, CPHA fixed at 0) with
// a programmable SCK divider, selectable idle polarity and NUM_CS registered
// active-low chip selects. Intended to sit between CPU I/O decode glue
// (DivMMC, ZXMMC, ...) and the SD/MMC SPI pins, entirely in clk_sys.
//
// Ports:
//   clk_sys     system clock, all logic on posedge
//   reset       synchronous active-high reset, aborts any transfer
//   div         SCK half-period minus one (clk_sys cycles), latched at start
//   cpol        SCK idle level, latched at start
//   tx / rx     one-cycle start strobes; tx sends din, rx sends 8'hFF
//   din         transmit byte
//   dout        last completed received byte (held until next completion)
//   busy        transfer in progress
//   done        one-cycle pulse at transfer completion
//   ss_we       load chip-select register from ss_din (any state)
//   ss_din      chip-select value
//   spi_ss      chip selects, active low, registered
//   spi_clk     SCK, registered
//   spi_di      MISO
//   spi_do      MOSI, always shreg[7]
//   sd_activity busy or any chip select asserted (activity LED)
//
// Handshake: a start strobe is accepted only on a clk_sys edge where the
// engine is idle (busy=0); strobes while busy=1 are dropped, nothing is
// queued. done rises for exactly one cycle after the last SCK edge, and a
// strobe presented in that done cycle is accepted, so back-to-back transfers
// are separated by a single idle cycle.
module spi_master_gen #(
  parameter int NUM_CS = 2,
  parameter int DIV_W  = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [DIV_W-1:0]  div,
  input  logic              cpol,
  input  logic              tx,
  input  logic              rx,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              busy,
  output logic              done,
  input  logic              ss_we,
  input  logic [NUM_CS-1:0] ss_din,
  output logic [NUM_CS-1:0] spi_ss,
  output logic              spi_clk,
  input  logic              spi_di,
  output logic              spi_do,
  output logic              sd_activity
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // state is kept as a named internal signal so checkers can bind to it.
  state_t state;
  state_t state_next;

  logic [DIV_W-1:0] div_l;
  logic             cpol_l;
  logic [DIV_W-1:0] divcnt;
  logic [4:0]       edgecnt;
  logic [7:0]       shreg;
  logic             rxbit;

  // Decoded control for the datapath.
  logic start;   // accept a strobe this edge
  logic tick;    // divider wrapped: SCK toggles this edge
  logic last;    // this toggle is the 16th, transfer completes

  always_comb begin
    state_next = state;
    start      = 1'b0;
    tick       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (tx | rx) begin
          start      = 1'b1;
          state_next = XFER;
        end
      end
      XFER: begin
        if (divcnt == div_l) begin
          tick = 1'b1;
          if (edgecnt == 5'd15) begin
            last       = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_l   <= '0;
      cpol_l  <= 1'b0;
      divcnt  <= '0;
      edgecnt <= 5'd0;
      shreg   <= 8'hFF;
      rxbit   <= 1'b0;
      dout    <= 8'hFF;
      busy    <= 1'b0;
      done    <= 1'b0;
      spi_ss  <= '1;
      spi_clk <= 1'b0;
    end else begin
      done <= 1'b0;

      // Chip selects are independent of the transfer engine; the glue owns
      // any sequencing between ss changes and transfers.
      if (ss_we) begin
        spi_ss <= ss_din;
      end

      if (state == IDLE) begin
        // SCK follows the live cpol input while idle so the bus shows the
        // selected idle level before the first transfer.
        spi_clk <= cpol;
        if (start) begin
          div_l   <= div;
          cpol_l  <= cpol;
          shreg   <= tx ? din : 8'hFF;
          divcnt  <= '0;
          edgecnt <= 5'd0;
          busy    <= 1'b1;
        end
      end else begin
        if (tick) begin
          divcnt  <= '0;
          edgecnt <= edgecnt + 5'd1;
          if (last) begin
            // Final trailing edge: SCK back to idle, byte complete.
            spi_clk <= cpol_l;
            shreg   <= {shreg[6:0], rxbit};
            dout    <= {shreg[6:0], rxbit};
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            spi_clk <= ~spi_clk;
            // edgecnt holds the number of toggles already made, so an even
            // count means this toggle is a leading (odd-numbered) edge.
            if (!edgecnt[0]) begin
              rxbit <= spi_di;
            end else begin
              shreg <= {shreg[6:0], rxbit};
            end
          end
        end else begin
          divcnt <= divcnt + 1'b1;
        end
      end
    end
  end

  assign spi_do      = shreg[7];
  assign sd_activity = busy | ~&spi_ss;

endmodule

// File: tb/tb_spi_master_gen.sv
// Self-checking bench for spi_master_gen. A negedge monitor compares MOSI at
// every leading SCK edge and dout at every done pulse against scoreboard
// queues filled by the strobe driver; scenario tasks check timing and status.
module tb_spi_master_gen;
  localparam int NUM_CS = 2;
  localparam int DIV_W  = 4;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic [DIV_W-1:0]  div;
  logic              cpol;
  logic              tx;
  logic              rx;
  logic [7:0]        din;
  logic [7:0]        dout;
  logic              busy;
  logic              done;
  logic              ss_we;
  logic [NUM_CS-1:0] ss_din;
  logic [NUM_CS-1:0] spi_ss;
  logic              spi_clk;
  logic              spi_di;
  logic              spi_do;
  logic              sd_activity;

  int vectors     = 0;
  int miscompares = 0;

  // Slave model controls.
  logic       loopback  = 1'b0;
  logic [7:0] miso_byte = 8'h00;
  logic [2:0] miso_idx  = 3'd0;
  logic       mon_cpol  = 1'b0;
  logic       prev_clk  = 1'b0;
  logic       prev_busy = 1'b0;

  logic [0:0] exp_mosi_q[$];
  logic [7:0] exp_q[$];

  assign spi_di = loopback ? spi_do : miso_byte[3'd7 - miso_idx];

  spi_master_gen #(.NUM_CS(NUM_CS), .DIV_W(DIV_W)) dut (
    .clk_sys(clk_sys), .reset(reset), .div(div), .cpol(cpol),
    .tx(tx), .rx(rx), .din(din), .dout(dout), .busy(busy), .done(done),
    .ss_we(ss_we), .ss_din(ss_din), .spi_ss(spi_ss), .spi_clk(spi_clk),
    .spi_di(spi_di), .spi_do(spi_do), .sd_activity(sd_activity)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_sys) begin
    logic [0:0] em;
    logic [7:0] ed;
    if (reset) begin
      prev_clk  = spi_clk;
      prev_busy = 1'b0;
    end else begin
      if (busy && !prev_busy) miso_idx = 3'd0;
      if (busy && (spi_clk !== prev_clk) && (spi_clk === ~mon_cpol)) begin
        vectors++;
        if (exp_mosi_q.size() == 0) begin
          miscompares++;
          $display("FAIL mosi_unexpected: leading edge with spi_do=%b, required no edge", spi_do);
        end else begin
          em = exp_mosi_q.pop_front();
          if (spi_do !== em[0]) begin
            miscompares++;
            $display("FAIL mosi_bit: spi_do=%b, required %b", spi_do, em[0]);
          end
        end
        miso_idx = miso_idx + 3'd1;
      end
      if (done === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL dout_unexpected: done with dout=%h, required no done", dout);
        end else begin
          ed = exp_q.pop_front();
          if (dout !== ed) begin
            miscompares++;
            $display("FAIL dout_done: dout=%h, required %h", dout, ed);
          end
        end
      end
      prev_clk  = spi_clk;
      prev_busy = busy;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the strobe was sampled.
  task automatic drive_strobe(input logic is_tx, input logic [7:0] data,
                              input logic [DIV_W-1:0] d, input logic c,
                              input logic [7:0] exp_byte);
    div      = d;
    cpol     = c;
    mon_cpol = c;
    din      = data;
    if (is_tx) tx = 1'b1; else rx = 1'b1;
    for (int i = 7; i >= 0; i--) exp_mosi_q.push_back(is_tx ? data[i] : 1'b1);
    exp_q.push_back(exp_byte);
    @(negedge clk_sys);
    tx = 1'b0;
    rx = 1'b0;
  endtask

  // Counts busy cycles until busy drops (bounded); ends on the done cycle.
  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 4000) begin
      n++;
      @(negedge clk_sys);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; div = '0; cpol = 1'b0; tx = 1'b0; rx = 1'b0; din = 8'h00;
    ss_we = 1'b0; ss_din = '0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    vectors++; if (spi_ss !== 2'b11) begin miscompares++; $display("FAIL reset_ss: %b, required 11", spi_ss); end
    vectors++; if (spi_clk !== 1'b0) begin miscompares++; $display("FAIL reset_clk: %b, required 0", spi_clk); end
    vectors++; if (spi_do !== 1'b1) begin miscompares++; $display("FAIL reset_do: %b, required 1", spi_do); end
    vectors++; if (dout !== 8'hFF) begin miscompares++; $display("FAIL reset_dout: %h, required ff", dout); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: %b, required 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: %b, required 0", done); end
    vectors++; if (sd_activity !== 1'b0) begin miscompares++; $display("FAIL reset_act: %b, required 0", sd_activity); end
  endtask

  task automatic test_tx_loopback();
    int n;
    loopback = 1'b1;
    drive_strobe(1'b1, 8'hA5, 4'd0, 1'b0, 8'hA5);
    wait_busy(n);
    vectors++; if (n != 16) begin miscompares++; $display("FAIL tx_busy_len: %0d, required 16", n); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL tx_done: %b, required 1", done); end
    vectors++; if (dout !== 8'hA5) begin miscompares++; $display("FAIL tx_dout: %h, required a5", dout); end
    @(negedge clk_sys);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL tx_done_pulse: %b, required 0", done); end
    vectors++; if (spi_clk !== 1'b0) begin miscompares++; $display("FAIL tx_clk_idle: %b, required 0", spi_clk); end
  endtask

  task automatic test_rx_cpol1();
    int n;
    int tog[4];
    int nt;
    logic pc;
    loopback  = 1'b0;
    miso_byte = 8'h3C;
    cpol      = 1'b1;
    mon_cpol  = 1'b1;
    repeat (2) @(negedge clk_sys);
    vectors++; if (spi_clk !== 1'b1) begin miscompares++; $display("FAIL rx_idle_high: %b, required 1", spi_clk); end
    drive_strobe(1'b0, 8'h00, 4'd3, 1'b1, 8'h3C);
    n = 0; nt = 0; pc = spi_clk;
    for (int i = 0; i < 4; i++) tog[i] = -1;
    while (busy === 1'b1 && n < 4000) begin
      if (spi_clk !== pc && nt < 4) begin tog[nt] = n; nt++; end
      pc = spi_clk;
      n++;
      @(negedge clk_sys);
    end
    vectors++; if (tog[0] != 4) begin miscompares++; $display("FAIL rx_first_edge: %0d, required 4", tog[0]); end
    vectors++; if (tog[1] != 8) begin miscompares++; $display("FAIL rx_second_edge: %0d, required 8", tog[1]); end
    vectors++; if (n != 64) begin miscompares++; $display("FAIL rx_busy_len: %0d, required 64", n); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rx_done: %b, required 1", done); end
    vectors++; if (dout !== 8'h3C) begin miscompares++; $display("FAIL rx_dout: %h, required 3c", dout); end
    vectors++; if (spi_clk !== 1'b1) begin miscompares++; $display("FAIL rx_clk_end: %b, required 1", spi_clk); end
  endtask

  task automatic test_back_to_back();
    int n;
    loopback = 1'b1;
    cpol = 1'b0; mon_cpol = 1'b0;
    repeat (2) @(negedge clk_sys);
    drive_strobe(1'b1, 8'h5A, 4'd1, 1'b0, 8'h5A);
    n = 0;
    while (busy === 1'b1 && n < 4000) begin
      if (n == 5) begin tx = 1'b1; din = 8'hFF; div = 4'd7; end
      if (n == 6) tx = 1'b0;
      n++;
      @(negedge clk_sys);
    end
    vectors++; if (n != 32) begin miscompares++; $display("FAIL b2b_first_len: %0d, required 32", n); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_done: %b, required 1", done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_gap: %b, required 0", busy); end
    // Strobe during the done cycle.
    drive_strobe(1'b1, 8'hC3, 4'd0, 1'b0, 8'hC3);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_restart: busy=%b, required 1", busy); end
    wait_busy(n);
    vectors++; if (n != 16) begin miscompares++; $display("FAIL b2b_second_len: %0d, required 16", n); end
    vectors++; if (dout !== 8'hC3) begin miscompares++; $display("FAIL b2b_dout: %h, required c3", dout); end
  endtask

  task automatic test_ss_activity();
    int n;
    loopback  = 1'b0;
    miso_byte = 8'h96;
    @(negedge clk_sys);
    drive_strobe(1'b0, 8'h00, 4'd0, 1'b0, 8'h96);
    @(negedge clk_sys);
    ss_we = 1'b1; ss_din = 2'b10;
    @(negedge clk_sys);
    ss_we = 1'b0;
    vectors++; if (spi_ss !== 2'b10) begin miscompares++; $display("FAIL ss_load: %b, required 10", spi_ss); end
    vectors++; if (sd_activity !== 1'b1) begin miscompares++; $display("FAIL ss_act_busy: %b, required 1", sd_activity); end
    wait_busy(n);
    vectors++; if (n != 14) begin miscompares++; $display("FAIL ss_busy_rest: %0d, required 14", n); end
    vectors++; if (dout !== 8'h96) begin miscompares++; $display("FAIL ss_dout: %h, required 96", dout); end
    @(negedge clk_sys);
    vectors++; if (sd_activity !== 1'b1) begin miscompares++; $display("FAIL ss_act_cs: %b, required 1", sd_activity); end
    ss_we = 1'b1; ss_din = 2'b11;
    @(negedge clk_sys);
    ss_we = 1'b0;
    vectors++; if (sd_activity !== 1'b0) begin miscompares++; $display("FAIL ss_act_off: %b, required 0", sd_activity); end
  endtask

  task automatic test_reset_mid();
    int n;
    loopback = 1'b1;
    ss_we = 1'b1; ss_din = 2'b00;
    @(negedge clk_sys);
    ss_we = 1'b0;
    cpol = 1'b1; mon_cpol = 1'b1;
    repeat (2) @(negedge clk_sys);
    drive_strobe(1'b1, 8'h77, 4'd0, 1'b1, 8'h77);
    repeat (7) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: %b, required 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: %b, required 0", done); end
    vectors++; if (spi_clk !== 1'b0) begin miscompares++; $display("FAIL rst_clk: %b, required 0", spi_clk); end
    vectors++; if (dout !== 8'hFF) begin miscompares++; $display("FAIL rst_dout: %h, required ff", dout); end
    vectors++; if (spi_ss !== 2'b11) begin miscompares++; $display("FAIL rst_ss: %b, required 11", spi_ss); end
    reset = 1'b0;
    exp_mosi_q.delete();
    exp_q.delete();
    cpol = 1'b0; mon_cpol = 1'b0;
    repeat (2) @(negedge clk_sys);
    drive_strobe(1'b1, 8'h3E, 4'd0, 1'b0, 8'h3E);
    wait_busy(n);
    vectors++; if (n != 16) begin miscompares++; $display("FAIL rst_fresh_len: %0d, required 16", n); end
    vectors++; if (dout !== 8'h3E) begin miscompares++; $display("FAIL rst_fresh_dout: %h, required 3e", dout); end
  endtask

  task automatic test_random();
    int n;
    logic [7:0] b;
    logic [DIV_W-1:0] d;
    loopback = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom_range(0, 255));
      d = DIV_W'($urandom_range(0, 15));
      if (k == 0) d = '1;
      cpol = 1'(k & 1); mon_cpol = 1'(k & 1);
      repeat (2) @(negedge clk_sys);
      drive_strobe(1'b1, b, d, 1'(k & 1), b);
      wait_busy(n);
      vectors++;
      if (n != 16 * (int'(d) + 1)) begin
        miscompares++;
        $display("FAIL rand_len: %0d, required %0d", n, 16 * (int'(d) + 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_tx_loopback();
    test_rx_cpol1();
    test_back_to_back();
    test_ss_activity();
    test_reset_mid();
    test_random();
    @(negedge clk_sys);
    vectors++;
    if (exp_mosi_q.size() != 0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d/%0d left, required 0/0", exp_mosi_q.size(), exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
